// File: rtl/hazard_unit.sv
// Pipeline hazard controller: tracks E/M/W destination shadows and drives
// stall, flush and forwarding selects plus saturating stall/flush counters.
module hazard_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             reg_write_d,
    input  logic [1:0]       result_src_d,
    input  logic             pc_src_e,
    input  logic             mem_busy_m,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic             stall_e,
    output logic             stall_m,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] SrcLoad = 2'b01;
    localparam logic [1:0] SrcPc4  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic [1:0] result_src;
    } stage_t;

    stage_t     e_q, e_d, m_q, m_d;
    logic [4:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
    logic       valid_w_q, valid_w_d, reg_write_w_q, reg_write_w_d;
    logic [4:0] rd_w_q, rd_w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic m_wr, w_wr;

    assign load_use = valid_d && e_q.valid && (e_q.result_src == SrcLoad) && (e_q.rd != 5'd0)
                      && ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
    assign m_wr = m_q.valid && m_q.reg_write && (m_q.rd != 5'd0);
    assign w_wr = valid_w_q && reg_write_w_q && (rd_w_q != 5'd0);

    // Priority: memory stall, then control flush, then load-use.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            if (mem_busy_m) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // M beats W; an M-stage load match is excluded by the load-use stall.
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (!reset) begin
            if (w_wr && (rd_w_q == rs1_e_q)) fwd_a_e = 2'b01;
            if (w_wr && (rd_w_q == rs2_e_q)) fwd_b_e = 2'b01;
            if (m_wr && (m_q.rd == rs1_e_q)) fwd_a_e = (m_q.result_src == SrcPc4) ? 2'b11 : 2'b10;
            if (m_wr && (m_q.rd == rs2_e_q)) fwd_b_e = (m_q.result_src == SrcPc4) ? 2'b11 : 2'b10;
        end
    end

    always_comb begin
        e_d           = e_q;
        m_d           = m_q;
        rs1_e_d       = rs1_e_q;
        rs2_e_d       = rs2_e_q;
        valid_w_d     = 1'b0;
        reg_write_w_d = 1'b0;
        rd_w_d        = rd_w_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (!mem_busy_m) begin
            valid_w_d     = m_q.valid;
            reg_write_w_d = m_q.reg_write;
            rd_w_d        = m_q.rd;
            m_d           = e_q;
            if (flush_e) begin
                e_d = '0;
            end else begin
                e_d.valid      = valid_d;
                e_d.rd         = rd_d;
                e_d.reg_write  = reg_write_d && valid_d;
                e_d.result_src = result_src_d;
            end
            rs1_e_d = rs1_d;
            rs2_e_d = rs2_d;
        end
        if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q           <= '0;
            m_q           <= '0;
            rs1_e_q       <= '0;
            rs2_e_q       <= '0;
            valid_w_q     <= 1'b0;
            reg_write_w_q <= 1'b0;
            rd_w_q        <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            e_q           <= e_d;
            m_q           <= m_d;
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            valid_w_q     <= valid_w_d;
            reg_write_w_q <= reg_write_w_d;
            rd_w_q        <= rd_w_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit: forwarding, load-use, control flush,
// memory stall, reset and counter saturation (narrow counters).
module tb_hazard_unit;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_d;
    logic [4:0]    rs1_d, rs2_d, rd_d;
    logic          reg_write_d;
    logic [1:0]    result_src_d;
    logic          pc_src_e, mem_busy_m;
    logic          stall_f, stall_d, flush_d, flush_e, stall_e, stall_m;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_count, flush_count;
    logic [5:0]    ctl;
    int            checks = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

    hazard_unit #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_d(rd_d), .reg_write_d(reg_write_d), .result_src_d(result_src_d),
        .pc_src_e(pc_src_e), .mem_busy_m(mem_busy_m), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e), .stall_e(stall_e), .stall_m(stall_m),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d, input logic rw, input logic [1:0] src);
        valid_d = v; rs1_d = s1; rs2_d = s2; rd_d = d; reg_write_d = rw; result_src_d = src;
    endtask

    task automatic drain();
        drive_d(0, 0, 0, 0, 0, 2'b00);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1; mem_busy_m = 1; pc_src_e = 1;
        drive_d(0, 0, 0, 0, 0, 2'b00);
        #1;
        checks++; if (ctl !== 6'b0) $display("FAIL rst_gates_ctl got %b want 000000", ctl); else passed++;
        tick();
        checks++; if ({stall_count, flush_count} !== 6'b0)
            $display("FAIL rst_counters got %b/%b want 0/0", stall_count, flush_count); else passed++;
        mem_busy_m = 0; pc_src_e = 0; reset = 0;
        #1;
        checks++; if ({ctl, fwd_a_e, fwd_b_e} !== 10'b0)
            $display("FAIL rst_outputs got %b %b %b want 0", ctl, fwd_a_e, fwd_b_e); else passed++;
    endtask

    task automatic test_fwd();
        drive_d(1, 1, 0, 5, 1, 2'b00); tick();
        drive_d(1, 5, 5, 6, 1, 2'b00); #1;
        checks++; if (ctl !== 6'b0) $display("FAIL alu_no_stall got %b want 000000", ctl); else passed++;
        tick(); drive_d(0, 0, 0, 0, 0, 2'b00); #1;
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b1010)
            $display("FAIL fwd_m got %b%b want 1010", fwd_a_e, fwd_b_e); else passed++;
        drain();
        drive_d(1, 1, 0, 5, 1, 2'b00); tick();
        drive_d(1, 0, 0, 0, 1, 2'b00); tick();
        drive_d(1, 5, 0, 7, 1, 2'b00); tick();
        drive_d(0, 0, 0, 0, 0, 2'b00); #1;
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0100)
            $display("FAIL fwd_w got %b%b want 0100", fwd_a_e, fwd_b_e); else passed++;
        drain();
    endtask

    task automatic test_double_producer();
        drive_d(1, 1, 0, 5, 1, 2'b00); tick();
        drive_d(1, 2, 0, 5, 1, 2'b00); tick();
        drive_d(1, 5, 2, 9, 1, 2'b00); tick();
        drive_d(0, 0, 0, 0, 0, 2'b00); #1;
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b1000)
            $display("FAIL double_m_wins got %b%b want 1000", fwd_a_e, fwd_b_e); else passed++;
        drain();
        drive_d(1, 1, 0, 0, 1, 2'b00); tick();
        drive_d(1, 2, 0, 0, 1, 2'b00); tick();
        drive_d(1, 0, 0, 9, 1, 2'b00); tick();
        drive_d(0, 0, 0, 0, 0, 2'b00); #1;
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0000)
            $display("FAIL double_x0 got %b%b want 0000", fwd_a_e, fwd_b_e); else passed++;
        drain();
    endtask

    task automatic test_load_use();
        drive_d(1, 2, 0, 7, 1, 2'b01); tick();
        drive_d(1, 7, 1, 8, 1, 2'b00); #1;
        checks++; if (ctl !== 6'b110001) $display("FAIL lu_stall got %b want 110001", ctl); else passed++;
        tick(); #1;
        checks++; if (ctl !== 6'b0) $display("FAIL lu_one_bubble got %b want 000000", ctl); else passed++;
        checks++; if (stall_count !== 3'd1)
            $display("FAIL lu_stall_count got %0d want 1", stall_count); else passed++;
        tick(); drive_d(0, 0, 0, 0, 0, 2'b00); #1;
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0100)
            $display("FAIL lu_fwd_w got %b%b want 0100", fwd_a_e, fwd_b_e); else passed++;
        drain();
        drive_d(1, 2, 0, 0, 1, 2'b01); tick();
        drive_d(1, 0, 0, 8, 1, 2'b00); #1;
        checks++; if (ctl !== 6'b0) $display("FAIL lu_x0_no_stall got %b want 000000", ctl); else passed++;
        tick();
        drain();
    endtask

    task automatic test_jal_fwd();
        drive_d(1, 0, 0, 1, 1, 2'b10); tick();
        drive_d(1, 1, 3, 4, 1, 2'b00); tick();
        drive_d(0, 0, 0, 0, 0, 2'b00); #1;
        checks++; if ({fwd_a_e, fwd_b_e} !== 4'b1100)
            $display("FAIL jal_fwd got %b%b want 1100", fwd_a_e, fwd_b_e); else passed++;
        drain();
    endtask

    task automatic test_flush_over_load_use();
        drive_d(1, 2, 0, 9, 1, 2'b01); tick();
        drive_d(1, 9, 0, 3, 1, 2'b00); pc_src_e = 1; #1;
        checks++; if (ctl !== 6'b000011) $display("FAIL flush_lu got %b want 000011", ctl); else passed++;
        tick(); pc_src_e = 0; drive_d(0, 0, 0, 0, 0, 2'b00); #1;
        checks++; if ({stall_count, flush_count} !== {3'd1, 3'd1})
            $display("FAIL flush_lu_counts got %0d/%0d want 1/1", stall_count, flush_count);
        else passed++;
        drain();
    endtask

    task automatic test_mem_busy();
        mem_busy_m = 1; pc_src_e = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== 6'b111100)
                $display("FAIL mem_stall_%0d got %b want 111100", i, ctl); else passed++;
            tick();
        end
        mem_busy_m = 0; #1;
        checks++; if (ctl !== 6'b000011) $display("FAIL mem_then_flush got %b want 000011", ctl);
        else passed++;
        tick(); pc_src_e = 0; #1;
        checks++; if ({stall_count, flush_count} !== {3'd4, 3'd2})
            $display("FAIL mem_counts got %0d/%0d want 4/2", stall_count, flush_count); else passed++;
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive_d(1, 1, 0, 5, 1, 2'b00); tick();
        drive_d(1, 5, 0, 6, 1, 2'b00); tick();
        drive_d(0, 0, 0, 0, 0, 2'b00); mem_busy_m = 1; pc_src_e = 1; #1;
        checks++; if ({ctl, fwd_a_e} !== 8'b111100_10)
            $display("FAIL rs_pre got %b %b want 111100 10", ctl, fwd_a_e); else passed++;
        tick(); reset = 1; #1;
        checks++; if ({ctl, fwd_a_e, fwd_b_e} !== 10'b0)
            $display("FAIL rs_during got %b %b %b want 0", ctl, fwd_a_e, fwd_b_e); else passed++;
        tick(); reset = 0; mem_busy_m = 0; pc_src_e = 0; #1;
        checks++; if ({ctl, fwd_a_e, fwd_b_e} !== 10'b0)
            $display("FAIL rs_after got %b %b %b want 0", ctl, fwd_a_e, fwd_b_e); else passed++;
        checks++; if ({stall_count, flush_count} !== 6'b0)
            $display("FAIL rs_counts got %0d/%0d want 0/0", stall_count, flush_count); else passed++;
    endtask

    task automatic test_saturation();
        mem_busy_m = 1;
        repeat (9) tick();
        mem_busy_m = 0; #1;
        checks++; if ({stall_count, flush_count} !== {3'd7, 3'd0})
            $display("FAIL sat_counts got %0d/%0d want 7/0", stall_count, flush_count); else passed++;
        drain();
    endtask

    initial begin
        reset = 1; pc_src_e = 0; mem_busy_m = 0;
        drive_d(0, 0, 0, 0, 0, 2'b00);
        test_reset();
        test_fwd();
        test_double_producer();
        test_load_use();
        test_jal_fwd();
        test_flush_over_load_use();
        test_mem_busy();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RV32I core. It sits beside the decode-stage control unit and consumes the decode-side control signals and register addresses. It keeps its own E/M/W shadow pipeline of destination registers and write-back controls. From that state it drives stall, flush and forwarding selects back into the datapath, plus saturating stall/flush event counters.

## Interface
- CNT_W, default 16: width of the event counters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
- valid_d  in  1  decode stage holds a real instruction.
- rs1_d, rs2_d  in  5 each  source registers of the decode instruction.
- rd_d  in  5  destination of the decode instruction.
- reg_write_d  in  1  decode instruction writes rd.
- result_src_d  in  2  00 ALU, 01 load, 10 PC+4.
- pc_src_e  in  1  branch taken or jump resolved in E.
- mem_busy_m  in  1  data memory not ready for the op in M.
- stall_f, stall_d  out  1 each  hold the PC and IF/ID registers.
- flush_d, flush_e  out  1 each  bubble the IF/ID and ID/EX registers.
- stall_e, stall_m  out  1 each  hold the ID/EX and EX/MEM registers.
- fwd_a_e, fwd_b_e  out  2 each  operand select: 00 register file, 01 W result, 10 M ALU result, 11 M PC+4.
- stall_count, flush_count  out  CNT_W each  saturating event counters.

## Operation
- Shadow stages E, M, W each hold: valid, rd, rs1, rs2 (E only), reg_write, result_src.
- Normal advance each cycle: D→E→M→W.
- Forwarding is combinational from shadow E/M/W. It applies to rs1 (fwd_a_e) and rs2 (fwd_b_e) independently.
  - M match: valid_m && reg_write_m && rd_m!=0 && rd_m==rs_e. Select 11 if result_src_m==10, else 10.
  - M match with result_src_m==01 cannot occur; load-use stall prevents it.
  - Otherwise W match (same conditions on W) gives 01. Otherwise 00.
  - M takes priority over W.
- Load-use hazard: valid_e && result_src_e==01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d), qualified by valid_d.
  - Response: stall_f=stall_d=1, flush_e=1.
  - Next cycle E holds a bubble (valid 0, reg_write 0). D is unchanged.
- Control hazard: pc_src_e=1 gives flush_d=flush_e=1, with stall_f/stall_d forced to 0.
- Memory stall: mem_busy_m=1 gives stall_f=stall_d=stall_e=stall_m=1 and all flushes 0.
  - E and M shadows hold. W takes a bubble.
- Priority, highest first: reset, memory stall, control flush, load-use stall.
  - pc_src_e during a memory stall is not lost. E is frozen, so it re-presents and flushes on the first cycle mem_busy_m=0.
  - Load-use coincident with pc_src_e: flush only. The stalled instruction is wrong-path.
- stall_count increments by 1 per cycle with stall_d=1 (load-use or memory). flush_count increments by 1 per cycle with flush_d=1. Both hold at all-ones.

## Timing
- All stall, flush and fwd outputs are combinational from inputs plus shadow state: zero-cycle latency.
- Shadow registers and counters update on rising clk.
- Reset (synchronous) clears all shadow valid, reg_write, rd and result_src fields to 0 and both counters to 0.
  - Outputs during and after reset: stall_*=0, flush_*=0, fwd_*=00.
- Reset asserted mid-stall or mid-flush: state is cleared on that edge. No pending flush survives reset.
- Load-use costs exactly one bubble. A taken branch costs exactly two bubbles (D and E). A memory stall costs one cycle per busy cycle.
- rd=x0 never forwards and never causes a stall.

## Test plan
- Forward from M: addi x5 in E, then add x6,x5,x5 in D. Next cycle fwd_a_e=fwd_b_e=10. One cycle later (producer in W): 01.
- Double producer: x5 written in both M and W with rs1_e=5. Required fwd_a_e=10. Same case with rd=0 in both: 00.
- Load-use: lw x7 in E, then add x8,x7,x1 in D. Required stall_f=stall_d=flush_e=1 for exactly 1 cycle, then fwd_a_e=01 on the following cycle; stall_count=1.
- Jump link forward: jal x1 in M, add uses x1 in E. Required fwd_a_e=11.
- pc_src_e=1 together with a load-use hazard. Required flush_d=flush_e=1, stall_d=0, flush_count+1, stall_count unchanged.
- mem_busy_m high for 3 cycles with pc_src_e=1. Required all stall_*=1 and no flush for 3 cycles, then flush_d=flush_e=1 on cycle 4. Assert reset in cycle 2 of a repeat run: all outputs 0 next cycle, counters 0.
